// File: rtl/alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : alu_rs_scheduler
//  Brief    : ALU reservation station. Holds dispatched ALU/branch/jump ops
//             until both operands are resolved from the ALU/LSB result buses,
//             then issues the lowest-index ready entry, one per cycle, through
//             registered issue ports.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_rs_scheduler #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_rdy,
  input  logic             i_rollback,
  // dispatch
  input  logic             i_disp_valid,
  output logic             o_disp_ready,
  input  logic [6:0]       i_disp_opcode,
  input  logic [2:0]       i_disp_funct3,
  input  logic             i_disp_funct7,
  input  logic [31:0]      i_disp_pc,
  input  logic [31:0]      i_disp_imm,
  input  logic [ROB_W-1:0] i_disp_rob_pos,
  input  logic             i_disp_q1_busy,
  input  logic [ROB_W-1:0] i_disp_q1,
  input  logic [31:0]      i_disp_v1,
  input  logic             i_disp_q2_busy,
  input  logic [ROB_W-1:0] i_disp_q2,
  input  logic [31:0]      i_disp_v2,
  // result broadcasts
  input  logic             i_alu_cdb_valid,
  input  logic [ROB_W-1:0] i_alu_cdb_rob_pos,
  input  logic [31:0]      i_alu_cdb_val,
  input  logic             i_lsb_cdb_valid,
  input  logic [ROB_W-1:0] i_lsb_cdb_rob_pos,
  input  logic [31:0]      i_lsb_cdb_val,
  // issue to ALU
  output logic             o_alu_enable,
  output logic [6:0]       o_alu_opcode,
  output logic [2:0]       o_alu_funct3,
  output logic             o_alu_funct7,
  output logic [31:0]      o_alu_val1,
  output logic [31:0]      o_alu_val2,
  output logic [31:0]      o_alu_imm,
  output logic [31:0]      o_alu_pc,
  output logic [ROB_W-1:0] o_alu_rob_pos
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);
  localparam logic [CNT_W-1:0] c_CNT_ALL = CNT_W'(RS_SIZE);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // entry storage
  logic             r_busy    [RS_SIZE];
  logic [6:0]       r_opcode  [RS_SIZE];
  logic [2:0]       r_funct3  [RS_SIZE];
  logic             r_funct7  [RS_SIZE];
  logic [31:0]      r_pc      [RS_SIZE];
  logic [31:0]      r_imm     [RS_SIZE];
  logic [ROB_W-1:0] r_rob_pos [RS_SIZE];
  logic             r_q1_busy [RS_SIZE];
  logic [ROB_W-1:0] r_q1      [RS_SIZE];
  logic [31:0]      r_v1      [RS_SIZE];
  logic             r_q2_busy [RS_SIZE];
  logic [ROB_W-1:0] r_q2      [RS_SIZE];
  logic [31:0]      r_v2      [RS_SIZE];
  logic [CNT_W-1:0] r_free_cnt;

  // registered issue port
  logic             r_alu_enable;
  logic [6:0]       r_alu_opcode;
  logic [2:0]       r_alu_funct3;
  logic             r_alu_funct7;
  logic [31:0]      r_alu_val1;
  logic [31:0]      r_alu_val2;
  logic [31:0]      r_alu_imm;
  logic [31:0]      r_alu_pc;
  logic [ROB_W-1:0] r_alu_rob_pos;

  logic             w_disp_ready;
  logic             w_disp_fire;
  logic             w_free_found;
  logic [IDX_W-1:0] w_free_idx;
  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_d_q1_busy;
  logic [31:0]      w_d_v1;
  logic             w_d_q2_busy;
  logic [31:0]      w_d_v2;

  // Full-refusal comes from registered state only, so a same-cycle issue
  // never opens a slot for dispatch.
  assign w_disp_ready = (r_free_cnt != '0);
  assign w_disp_fire  = i_disp_valid && w_disp_ready && w_free_found;
  assign o_disp_ready = w_disp_ready;

  assign o_alu_enable  = r_alu_enable;
  assign o_alu_opcode  = r_alu_opcode;
  assign o_alu_funct3  = r_alu_funct3;
  assign o_alu_funct7  = r_alu_funct7;
  assign o_alu_val1    = r_alu_val1;
  assign o_alu_val2    = r_alu_val2;
  assign o_alu_imm     = r_alu_imm;
  assign o_alu_pc      = r_alu_pc;
  assign o_alu_rob_pos = r_alu_rob_pos;

  // Lowest-index free entry (scan high to low so the lowest match wins).
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index ready entry; only registered operand state counts, so a
  // wakeup is never issued in the same cycle it arrives.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (r_busy[i] && !r_q1_busy[i] && !r_q2_busy[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  // Resolve dispatched operands against same-cycle broadcasts; ALU bus wins.
  always_comb begin
    w_d_q1_busy = i_disp_q1_busy;
    w_d_v1      = i_disp_v1;
    w_d_q2_busy = i_disp_q2_busy;
    w_d_v2      = i_disp_v2;
    if (i_disp_q1_busy) begin
      if (i_alu_cdb_valid && (i_alu_cdb_rob_pos == i_disp_q1)) begin
        w_d_q1_busy = 1'b0;
        w_d_v1      = i_alu_cdb_val;
      end else if (i_lsb_cdb_valid && (i_lsb_cdb_rob_pos == i_disp_q1)) begin
        w_d_q1_busy = 1'b0;
        w_d_v1      = i_lsb_cdb_val;
      end
    end
    if (i_disp_q2_busy) begin
      if (i_alu_cdb_valid && (i_alu_cdb_rob_pos == i_disp_q2)) begin
        w_d_q2_busy = 1'b0;
        w_d_v2      = i_alu_cdb_val;
      end else if (i_lsb_cdb_valid && (i_lsb_cdb_rob_pos == i_disp_q2)) begin
        w_d_q2_busy = 1'b0;
        w_d_v2      = i_lsb_cdb_val;
      end
    end
  end

  // Entry state, occupancy and issue port: reset, flush, then stall-gated
  // wakeup / issue / allocate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i]    <= 1'b0;
        r_opcode[i]  <= '0;
        r_funct3[i]  <= '0;
        r_funct7[i]  <= 1'b0;
        r_pc[i]      <= '0;
        r_imm[i]     <= '0;
        r_rob_pos[i] <= '0;
        r_q1_busy[i] <= 1'b0;
        r_q1[i]      <= '0;
        r_v1[i]      <= '0;
        r_q2_busy[i] <= 1'b0;
        r_q2[i]      <= '0;
        r_v2[i]      <= '0;
      end
      r_free_cnt    <= c_CNT_ALL;
      r_alu_enable  <= 1'b0;
      r_alu_opcode  <= '0;
      r_alu_funct3  <= '0;
      r_alu_funct7  <= 1'b0;
      r_alu_val1    <= '0;
      r_alu_val2    <= '0;
      r_alu_imm     <= '0;
      r_alu_pc      <= '0;
      r_alu_rob_pos <= '0;
    end else if (i_rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        r_busy[i] <= 1'b0;
      end
      r_free_cnt   <= c_CNT_ALL;
      r_alu_enable <= 1'b0;
    end else if (i_rdy) begin
      // wakeup of pending operands in occupied entries
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && r_q1_busy[i]) begin
          if (i_alu_cdb_valid && (i_alu_cdb_rob_pos == r_q1[i])) begin
            r_q1_busy[i] <= 1'b0;
            r_v1[i]      <= i_alu_cdb_val;
          end else if (i_lsb_cdb_valid && (i_lsb_cdb_rob_pos == r_q1[i])) begin
            r_q1_busy[i] <= 1'b0;
            r_v1[i]      <= i_lsb_cdb_val;
          end
        end
        if (r_busy[i] && r_q2_busy[i]) begin
          if (i_alu_cdb_valid && (i_alu_cdb_rob_pos == r_q2[i])) begin
            r_q2_busy[i] <= 1'b0;
            r_v2[i]      <= i_alu_cdb_val;
          end else if (i_lsb_cdb_valid && (i_lsb_cdb_rob_pos == r_q2[i])) begin
            r_q2_busy[i] <= 1'b0;
            r_v2[i]      <= i_lsb_cdb_val;
          end
        end
      end
      // issue; with no candidate the data fields hold
      r_alu_enable <= w_sel_found;
      if (w_sel_found) begin
        r_alu_opcode      <= r_opcode[w_sel_idx];
        r_alu_funct3      <= r_funct3[w_sel_idx];
        r_alu_funct7      <= r_funct7[w_sel_idx];
        r_alu_val1        <= r_v1[w_sel_idx];
        r_alu_val2        <= r_v2[w_sel_idx];
        r_alu_imm         <= r_imm[w_sel_idx];
        r_alu_pc          <= r_pc[w_sel_idx];
        r_alu_rob_pos     <= r_rob_pos[w_sel_idx];
        r_busy[w_sel_idx] <= 1'b0;
      end
      // allocation into a free slot (never the slot being issued)
      if (w_disp_fire) begin
        r_busy[w_free_idx]    <= 1'b1;
        r_opcode[w_free_idx]  <= i_disp_opcode;
        r_funct3[w_free_idx]  <= i_disp_funct3;
        r_funct7[w_free_idx]  <= i_disp_funct7;
        r_pc[w_free_idx]      <= i_disp_pc;
        r_imm[w_free_idx]     <= i_disp_imm;
        r_rob_pos[w_free_idx] <= i_disp_rob_pos;
        r_q1_busy[w_free_idx] <= w_d_q1_busy;
        r_q1[w_free_idx]      <= i_disp_q1;
        r_v1[w_free_idx]      <= w_d_v1;
        r_q2_busy[w_free_idx] <= w_d_q2_busy;
        r_q2[w_free_idx]      <= i_disp_q2;
        r_v2[w_free_idx]      <= w_d_v2;
      end
      // occupancy
      case ({w_sel_found, w_disp_fire})
        2'b10:   r_free_cnt <= r_free_cnt + c_CNT_ONE;
        2'b01:   r_free_cnt <= r_free_cnt - c_CNT_ONE;
        default: r_free_cnt <= r_free_cnt;
      endcase
    end
  end

`ifndef SYNTHESIS
  // A legal ROB never broadcasts one tag on both buses in the same cycle.
  a_cdb_tag_unique: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_alu_cdb_valid && i_lsb_cdb_valid && (i_alu_cdb_rob_pos == i_lsb_cdb_rob_pos)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_rs_scheduler
//  Brief    : Directed, table-driven bench for alu_rs_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rs_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy, rollback;
  logic        disp_valid, disp_ready;
  logic [6:0]  disp_opcode;
  logic [2:0]  disp_funct3;
  logic        disp_funct7;
  logic [31:0] disp_pc, disp_imm;
  logic [3:0]  disp_rob_pos;
  logic        disp_q1_busy, disp_q2_busy;
  logic [3:0]  disp_q1, disp_q2;
  logic [31:0] disp_v1, disp_v2;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_rob_pos, lsb_cdb_rob_pos;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        alu_enable;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int total = 0;
  int bad   = 0;

  alu_rs_scheduler #(.RS_SIZE(8), .ROB_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_rdy(rdy), .i_rollback(rollback),
    .i_disp_valid(disp_valid), .o_disp_ready(disp_ready),
    .i_disp_opcode(disp_opcode), .i_disp_funct3(disp_funct3), .i_disp_funct7(disp_funct7),
    .i_disp_pc(disp_pc), .i_disp_imm(disp_imm), .i_disp_rob_pos(disp_rob_pos),
    .i_disp_q1_busy(disp_q1_busy), .i_disp_q1(disp_q1), .i_disp_v1(disp_v1),
    .i_disp_q2_busy(disp_q2_busy), .i_disp_q2(disp_q2), .i_disp_v2(disp_v2),
    .i_alu_cdb_valid(alu_cdb_valid), .i_alu_cdb_rob_pos(alu_cdb_rob_pos), .i_alu_cdb_val(alu_cdb_val),
    .i_lsb_cdb_valid(lsb_cdb_valid), .i_lsb_cdb_rob_pos(lsb_cdb_rob_pos), .i_lsb_cdb_val(lsb_cdb_val),
    .o_alu_enable(alu_enable), .o_alu_opcode(alu_opcode), .o_alu_funct3(alu_funct3),
    .o_alu_funct7(alu_funct7), .o_alu_val1(alu_val1), .o_alu_val2(alu_val2),
    .o_alu_imm(alu_imm), .o_alu_pc(alu_pc), .o_alu_rob_pos(alu_rob_pos)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rob;
    logic        q1b;
    logic [3:0]  q1;
    logic [31:0] v1;
    logic        q2b;
    logic [3:0]  q2;
    logic [31:0] v2;
    logic        av;
    logic [3:0]  at;
    logic [31:0] ad;
    logic        lv;
    logic [3:0]  lt;
    logic [31:0] ld;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_opcode = '0; disp_funct3 = '0; disp_funct7 = 1'b0;
    disp_pc = '0; disp_imm = '0; disp_rob_pos = '0;
    disp_q1_busy = 1'b0; disp_q1 = '0; disp_v1 = '0;
    disp_q2_busy = 1'b0; disp_q2 = '0; disp_v2 = '0;
    alu_cdb_valid = 1'b0; alu_cdb_rob_pos = '0; alu_cdb_val = '0;
    lsb_cdb_valid = 1'b0; lsb_cdb_rob_pos = '0; lsb_cdb_val = '0;
  endtask

  task automatic drive(input vec_t v);
    disp_valid = 1'b1; disp_opcode = v.op; disp_funct3 = v.f3; disp_funct7 = v.f7;
    disp_pc = v.pc; disp_imm = v.imm; disp_rob_pos = v.rob;
    disp_q1_busy = v.q1b; disp_q1 = v.q1; disp_v1 = v.v1;
    disp_q2_busy = v.q2b; disp_q2 = v.q2; disp_v2 = v.v2;
    alu_cdb_valid = v.av; alu_cdb_rob_pos = v.at; alu_cdb_val = v.ad;
    lsb_cdb_valid = v.lv; lsb_cdb_rob_pos = v.lt; lsb_cdb_val = v.ld;
  endtask

  // dispatch of a plain ADD with operand 1 pending on tag q1
  task automatic disp_pending(input logic [3:0] rob, input logic [3:0] tag, input logic [31:0] v2);
    vec_t t;
    t = '0; t.op = 7'h33; t.rob = rob; t.q1b = 1'b1; t.q1 = tag; t.v2 = v2;
    drive(t);
  endtask

  task automatic disp_ready_op(input logic [3:0] rob, input logic [31:0] v1);
    vec_t t;
    t = '0; t.op = 7'h33; t.rob = rob; t.v1 = v1;
    drive(t);
  endtask

  initial begin
    vecs[0] = '{7'h33,3'h0,1'b0,32'h100,32'h0,4'd3,1'b0,4'd0,32'd5,1'b0,4'd0,32'd7,
                1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,32'd5,32'd7};
    vecs[1] = '{7'h33,3'h4,1'b0,32'h104,32'h0,4'd4,1'b1,4'd6,32'h0,1'b0,4'd0,32'h10,
                1'b0,4'd0,32'h0,1'b1,4'd6,32'h1234,32'h1234,32'h10};
    vecs[2] = '{7'h33,3'h0,1'b1,32'h108,32'h0,4'd5,1'b0,4'd0,32'd1,1'b1,4'd2,32'h0,
                1'b1,4'd2,32'hdeadbeef,1'b0,4'd0,32'h0,32'd1,32'hdeadbeef};
    vecs[3] = '{7'h13,3'h0,1'b0,32'h10c,32'hfffffffc,4'd7,1'b0,4'd0,32'h55,1'b0,4'd0,32'h0,
                1'b0,4'd0,32'h0,1'b0,4'd0,32'h0,32'h55,32'h0};
    vecs[4] = '{7'h63,3'h1,1'b0,32'h110,32'h8,4'd8,1'b1,4'd1,32'h0,1'b1,4'd5,32'h0,
                1'b1,4'd1,32'haaaa,1'b1,4'd5,32'hbbbb,32'haaaa,32'hbbbb};
    vecs[5] = '{7'h33,3'h7,1'b0,32'h114,32'h0,4'd9,1'b0,4'd6,32'h77,1'b0,4'd0,32'h3,
                1'b1,4'd6,32'h999,1'b0,4'd0,32'h0,32'h77,32'h3};
    vecs[6] = '{7'h33,3'h2,1'b0,32'h118,32'h0,4'd10,1'b1,4'd3,32'h0,1'b0,4'd0,32'h9,
                1'b1,4'd4,32'h111,1'b1,4'd3,32'h222,32'h222,32'h9};

    // reset
    idle();
    rdy = 1'b1; rollback = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);
    chk("reset_enable", 64'(alu_enable), 64'd0);
    chk("reset_fields", {alu_opcode, alu_funct3, alu_funct7, alu_rob_pos}, 64'd0);
    chk("reset_val1_val2", {alu_val1, alu_val2}, 64'd0);
    chk("reset_imm_pc", {alu_imm, alu_pc}, 64'd0);

    // table-driven single-instruction vectors
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k]);
      tick();
      idle();
      chk("vec_residency", 64'(alu_enable), 64'd0);
      tick();
      chk("vec_enable", 64'(alu_enable), 64'd1);
      chk("vec_val1", 64'(alu_val1), 64'(vecs[k].e1));
      chk("vec_val2", 64'(alu_val2), 64'(vecs[k].e2));
      chk("vec_rob", 64'(alu_rob_pos), 64'(vecs[k].rob));
      chk("vec_op", 64'({alu_opcode, alu_funct3, alu_funct7}), 64'({vecs[k].op, vecs[k].f3, vecs[k].f7}));
      chk("vec_pc_imm", {alu_pc, alu_imm}, {vecs[k].pc, vecs[k].imm});
      tick();
      chk("vec_idle_enable", 64'(alu_enable), 64'd0);
      chk("vec_hold_val1", 64'(alu_val1), 64'(vecs[k].e1));
    end

    // fill with 8 entries pending on tag 9
    for (int i = 0; i < 8; i++) begin
      disp_pending(4'(i), 4'd9, 32'(i));
      tick();
      chk("fill_disp_ready", 64'(disp_ready), (i < 7) ? 64'd1 : 64'd0);
    end
    idle();
    // refused dispatch while full
    disp_ready_op(4'd15, 32'hf);
    tick();
    idle();
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    chk("full_no_issue", 64'(alu_enable), 64'd0);
    // broadcast tag 9; issue must wait one cycle after wakeup
    lsb_cdb_valid = 1'b1; lsb_cdb_rob_pos = 4'd9; lsb_cdb_val = 32'h900;
    tick();
    idle();
    chk("wake_no_same_cycle", 64'(alu_enable), 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_enable", 64'(alu_enable), 64'd1);
      chk("drain_rob", 64'(alu_rob_pos), 64'(i));
      chk("drain_vals", {alu_val1, alu_val2}, {32'h900, 32'(i)});
    end
    chk("drain_disp_ready", 64'(disp_ready), 64'd1);
    tick();
    chk("drain_done", 64'(alu_enable), 64'd0);

    // stall with a ready entry, then rollback while still stalled
    disp_ready_op(4'd10, 32'h31);
    tick();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_enable", 64'(alu_enable), 64'd0);
      chk("stall_hold", {28'd0, alu_rob_pos, alu_val1}, {28'd0, 4'd7, 32'h900});
    end
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("rollback_enable", 64'(alu_enable), 64'd0);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rollback_never_issues", 64'(alu_enable), 64'd0);
    end
    chk("rollback_disp_ready", 64'(disp_ready), 64'd1);

    // same-cycle dispatch and issue at 7/8 occupancy
    for (int i = 0; i < 6; i++) begin
      disp_pending(4'(i), 4'd12, 32'd0);
      tick();
    end
    disp_ready_op(4'd14, 32'h61);
    tick();
    chk("occ7_disp_ready", 64'(disp_ready), 64'd1);
    disp_pending(4'd6, 4'd12, 32'd0);
    tick();
    chk("same_cycle_issue", {59'd0, alu_enable, alu_rob_pos}, {59'd0, 1'b1, 4'd14});
    chk("same_cycle_disp_ready", 64'(disp_ready), 64'd1);
    disp_pending(4'd7, 4'd12, 32'd0);
    tick();
    idle();
    chk("last_slot_full", 64'(disp_ready), 64'd0);
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    chk("flush_disp_ready", 64'(disp_ready), 64'd1);
    alu_cdb_valid = 1'b1; alu_cdb_rob_pos = 4'd12; alu_cdb_val = 32'h5;
    tick();
    idle();
    tick();
    chk("flushed_no_issue", 64'(alu_enable), 64'd0);
    tick();
    chk("flushed_no_issue2", 64'(alu_enable), 64'd0);

    // asynchronous reset between clock edges
    disp_ready_op(4'd2, 32'habc);
    tick();
    idle();
    tick();
    chk("pre_reset_issue", {31'd0, alu_enable, alu_val1}, {31'd0, 1'b1, 32'habc});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_enable", 64'(alu_enable), 64'd0);
    chk("async_reset_val1", 64'(alu_val1), 64'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {62'd0, disp_ready, alu_enable}, {62'd0, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rs_scheduler.md
# alu_rs_scheduler

Reservation station and issue scheduler for the integer ALU in the out-of-order core. It accepts decoded ALU/branch/jump instructions from dispatch, holds them until both source operands are resolved via the two common data buses (ALU and LSB result broadcasts), and issues at most one ready instruction per cycle to the ALU through registered issue ports. It sits between the dispatcher/ROB and the ALU, and owns the ALU's `enable` input.

## Interface
- `RS_SIZE`, 8: number of entries; power of two, 2..16.
- `ROB_W`, 4: width of ROB position tags.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; when 0, all state and outputs hold.
- `rollback`  in  1  misprediction flush; synchronous, takes priority over everything except `rst`.
- `disp_valid`  in  1  dispatch request this cycle.
- `disp_ready`  out  1  at least one free entry.
- `disp_opcode`  in  7  instruction opcode.
- `disp_funct3`  in  3  instruction funct3.
- `disp_funct7`  in  1  instruction funct7 bit 5.
- `disp_pc`  in  32  instruction PC.
- `disp_imm`  in  32  sign-extended immediate.
- `disp_rob_pos`  in  `ROB_W`  destination ROB tag.
- `disp_q1_busy`  in  1  operand 1 still pending.
- `disp_q1`  in  `ROB_W`  producer tag for operand 1.
- `disp_v1`  in  32  operand 1 value, used when not busy.
- `disp_q2_busy`, `disp_q2`, `disp_v2`: same as the operand 1 ports, for operand 2.
- `alu_cdb_valid`  in  1  ALU result broadcast valid.
- `alu_cdb_rob_pos`  in  `ROB_W`  tag of the ALU broadcast.
- `alu_cdb_val`  in  32  value of the ALU broadcast.
- `lsb_cdb_valid`, `lsb_cdb_rob_pos`, `lsb_cdb_val`: same as the ALU broadcast ports, for the load/store buffer broadcast.
- `alu_enable`  out  1  issue strobe to the ALU.
- `alu_opcode`  out  7  issued opcode.
- `alu_funct3`  out  3  issued funct3.
- `alu_funct7`  out  1  issued funct7 bit.
- `alu_val1`  out  32  issued operand 1.
- `alu_val2`  out  32  issued operand 2.
- `alu_imm`  out  32  issued immediate.
- `alu_pc`  out  32  issued PC.
- `alu_rob_pos`  out  `ROB_W`  issued ROB tag.

## Operation
- Each entry holds: busy, opcode, funct3, funct7, pc, imm, rob_pos, and per operand a pending flag, tag and value.
- **Allocation.** On `disp_valid && disp_ready`, write the lowest-index free entry.
- **Dispatch bypass.** A busy operand whose tag matches a valid CDB in the same cycle is stored as resolved, with the CDB value.
- **Wakeup.** Every cycle, each busy entry's pending operand compares its tag against both CDBs. On a match, store the value and clear pending.
- **CDB priority.** If both CDBs match the same tag, the ALU bus wins. A legal ROB never produces this case; it is covered by assertion only.
- **Selection.** Ready means busy and neither operand pending. Pick the lowest-index ready entry.
- **Issue.** On the clock edge, register the selected entry's fields onto the `alu_*` ports, set `alu_enable` = 1 and free the entry.
- **No candidate.** With no ready entry, `alu_enable` = 0 and the other `alu_*` outputs hold their previous values.
- **Occupancy.** A free-entry counter is maintained: +1 on issue, −1 on dispatch, unchanged when both happen in the same cycle.
- **`disp_ready`** = (free count ≠ 0), from registered state. When full, dispatch is refused even if an issue frees a slot that cycle.
- **Operand encoding.** `alu_val2` always carries `v2`; operand 2 of I-type, LUI, AUIPC and JAL is dispatched not-busy with value 0. The ALU selects `imm` itself.
- **`rollback`.** Clear all busy bits, set free count = `RS_SIZE`, `alu_enable` = 0. Dispatch and CDB in that cycle are ignored.
- **`rdy` = 0.** No allocation, wakeup, issue or counter change; outputs hold. CDB broadcasts during stall are not captured; producers hold them while stalled.

## Timing
- **Reset** (async, `rst` = 0): all entries free, free count = `RS_SIZE`, `disp_ready` = 1. `alu_enable` = 0 and all other `alu_*` outputs = 0.
- **Dispatch with operands ready**, sampled at edge E: `alu_enable` = 1 after edge E+1, i.e. 1-cycle minimum residency.
- **Woken operand.** An operand woken by a CDB at edge W is eligible for issue, with `alu_enable` = 1, after edge W+1. Same-cycle wakeup-and-issue is not supported.
- **Throughput:** one issue per cycle; `alu_enable` can be high on consecutive cycles.
- **`rst` mid-operation:** immediate clear regardless of `rdy` and `clk`.
- **`rollback` with `rdy` = 0:** rollback is still applied.

## Test plan
- **Reset check:** after reset → `disp_ready` = 1, `alu_enable` = 0, all `alu_*` = 0.
- **Basic issue:** dispatch ADD with v1 = 5, v2 = 7, both ready, rob_pos = 3 → one cycle later `alu_enable` = 1, `alu_val1` = 5, `alu_val2` = 7, `alu_rob_pos` = 3.
- **Dispatch bypass:** dispatch with q1 = 6 busy while `lsb_cdb` broadcasts tag 6, value 0x1234 → issues next cycle with `alu_val1` = 0x1234.
- **Fill and drain:** 8 dispatches with operands pending on tag 9 → `disp_ready` = 0 after the eighth. Broadcast tag 9 → 8 issues on 8 consecutive cycles in index order, then `disp_ready` = 1.
- **Stall then rollback:** hold `rdy` = 0 for 3 cycles with a ready entry → no issue and outputs unchanged. Then assert `rollback` → `alu_enable` = 0 and the entry never issues.
- **Same-cycle dispatch and issue** at 7/8 occupancy → free count unchanged and `disp_ready` stays 1.
